comando_vai_vem: RTL and testbench

//   Position controller that drives the vai/vem/enable_mov/pos interface of the saturating up/down position counter.
//   - On request, steps the counter from its current position to a target, one unit per step, at a fixed step rate.
//   - Reads back the counter output Q on pos.
//   - Reports busy/done/error to the supervising FSM. Sits between the game/control FSM and the position counter.

---
 rtl/comando_vai_vem.sv | 129 ++++++++++++
 tb/tb_comando_vai_vem.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/comando_vai_vem.sv
// comando_vai_vem
//   Position controller for the saturating up/down position counter.
//   On request it steps the counter from its current position (pos) to a
//   target (alvo), one unit per step, one step every PASSO+2 cycles, and
//   reports busy/done/error to the supervising FSM.
//
// Ports
//   clock       in   1  system clock, rising edge
//   zera_as_n   in   1  asynchronous reset, active low
//   iniciar     in   1  start request (accepted only when idle)
//   cancelar    in   1  abort the current move (any busy state)
//   alvo        in   N  target position, latched on accepted start
//   pos         in   N  current counter position (counter Q)
//   vai         out  1  step-up command
//   vem         out  1  step-down command
//   enable_mov  out  1  step strobe, one cycle per step
//   ocupado     out  1  high whenever not idle
//   pronto      out  1  one-cycle pulse: target reached
//   erro        out  1  one-cycle pulse: start rejected (alvo >= M)
module comando_vai_vem #(
  parameter int M     = 100,
  parameter int N     = 7,
  parameter int PASSO = 4
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         iniciar,
  input  logic         cancelar,
  input  logic [N-1:0] alvo,
  input  logic [N-1:0] pos,
  output logic         vai,
  output logic         vem,
  output logic         enable_mov,
  output logic         ocupado,
  output logic         pronto,
  output logic         erro
);

  localparam int TW = $clog2(PASSO) + 1;
  localparam logic [TW-1:0] LP_TMAX = TW'(PASSO - 1);
  // One extra bit so that M == 2**N still compares correctly.
  localparam logic [N:0]    LP_M    = (N+1)'(M);

  typedef enum logic [2:0] {
    OCIOSO,
    CHECA,
    MOVE,
    ESPERA,
    FIM
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox;
  logic [N-1:0]    r_alvo;
  logic            r_dir;
  logic [TW-1:0]   r_timer;
  logic            r_erro;

  logic            w_alvo_ok;
  logic            w_aceita;
  logic            w_rejeita;

  assign w_alvo_ok = ({1'b0, alvo} < LP_M);
  assign w_aceita  = (r_estado == OCIOSO) && iniciar && w_alvo_ok;
  assign w_rejeita = (r_estado == OCIOSO) && iniciar && !w_alvo_ok;

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox     = r_estado;
    vai        = 1'b0;
    vem        = 1'b0;
    enable_mov = 1'b0;
    ocupado    = 1'b1;
    pronto     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        ocupado = 1'b0;
        if (w_aceita) w_prox = CHECA;
      end
      CHECA: begin
        if (pos == r_alvo) w_prox = FIM;
        else               w_prox = MOVE;
      end
      MOVE: begin
        enable_mov = 1'b1;
        vai        = r_dir;
        vem        = ~r_dir;
        w_prox     = ESPERA;
      end
      ESPERA: begin
        if (r_timer == '0) w_prox = CHECA;
      end
      FIM: begin
        pronto = 1'b1;
        w_prox = OCIOSO;
      end
      default: begin
        w_prox = OCIOSO;
      end
    endcase
    // Abort wins over every busy-state transition.
    if (cancelar && (r_estado != OCIOSO)) w_prox = OCIOSO;
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      r_alvo  <= '0;
      r_dir   <= 1'b0;
      r_timer <= '0;
      r_erro  <= 1'b0;
    end else begin
      r_erro <= w_rejeita;
      if (w_aceita) r_alvo <= alvo;
      if (r_estado == CHECA && pos != r_alvo) r_dir <= (pos < r_alvo);
      if (r_estado == MOVE)                   r_timer <= LP_TMAX;
      else if (r_estado == ESPERA && r_timer != '0) r_timer <= r_timer - 1'b1;
    end
  end

  assign erro = r_erro;

endmodule

// File: tb/tb_comando_vai_vem.sv
module tb_comando_vai_vem;

  localparam int M     = 100;
  localparam int N     = 7;
  localparam int PASSO = 4;
  localparam int LOGSZ = 64;

  logic         clock;
  logic         zera_as_n;
  logic         iniciar;
  logic         cancelar;
  logic [N-1:0] alvo;
  logic [N-1:0] pos;
  logic         vai, vem, enable_mov, ocupado, pronto, erro;

  int checks;
  int errors;
  int both_viol;
  int c;
  logic en_log  [LOGSZ];
  logic vai_log [LOGSZ];
  logic vem_log [LOGSZ];
  logic pr_log  [LOGSZ];
  logic oc_log  [LOGSZ];
  logic er_log  [LOGSZ];

  comando_vai_vem #(.M(M), .N(N), .PASSO(PASSO)) dut (
    .clock      (clock),
    .zera_as_n  (zera_as_n),
    .iniciar    (iniciar),
    .cancelar   (cancelar),
    .alvo       (alvo),
    .pos        (pos),
    .vai        (vai),
    .vem        (vem),
    .enable_mov (enable_mov),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .erro       (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    c = 0;
    for (int i = 0; i < LOGSZ; i++) begin
      en_log[i] = 0; vai_log[i] = 0; vem_log[i] = 0;
      pr_log[i] = 0; oc_log[i] = 0; er_log[i] = 0;
    end
  endtask

  // One cycle: sample outputs mid-cycle, then let the modelled saturating
  // counter react to the strobe on the rising edge.
  task automatic cyc();
    logic s_en, s_vai, s_vem;
    @(negedge clock);
    s_en = enable_mov; s_vai = vai; s_vem = vem;
    if (vai && vem) both_viol++;
    if (c < LOGSZ) begin
      en_log[c] = enable_mov; vai_log[c] = vai; vem_log[c] = vem;
      pr_log[c] = pronto; oc_log[c] = ocupado; er_log[c] = erro;
    end
    c++;
    @(posedge clock);
    #1;
    if (s_en && zera_as_n) begin
      if (s_vai && pos < N'(M - 1)) pos = pos + 1'b1;
      else if (s_vem && pos > 0)    pos = pos - 1'b1;
    end
  endtask

  function automatic int cnt_en();
    int n = 0;
    for (int i = 0; i < LOGSZ; i++) if (en_log[i]) n++;
    return n;
  endfunction

  function automatic int cnt_pr();
    int n = 0;
    for (int i = 0; i < LOGSZ; i++) if (pr_log[i]) n++;
    return n;
  endfunction

  function automatic int cnt_oc();
    int n = 0;
    for (int i = 0; i < LOGSZ; i++) if (oc_log[i]) n++;
    return n;
  endfunction

  function automatic int cnt_er();
    int n = 0;
    for (int i = 0; i < LOGSZ; i++) if (er_log[i]) n++;
    return n;
  endfunction

  // Pulse iniciar during cycle 0, then run until cycle last.
  task automatic start_move(input int p, input int a, input int last);
    clear_logs();
    pos = N'(p); alvo = N'(a);
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    while (c <= last) cyc();
  endtask

  initial begin
    checks = 0; errors = 0; both_viol = 0; c = 0;
    zera_as_n = 1'b0; iniciar = 1'b0; cancelar = 1'b0;
    alvo = '0; pos = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ocupado", ocupado, 0);
    chk("rst_en", enable_mov, 0);
    chk("rst_outs", {vai, vem, pronto, erro}, 0);
    zera_as_n = 1'b1;
    cyc(); cyc();

    // 1: 10 -> 13 upward
    start_move(10, 13, 24);
    chk("t1_en2",  en_log[2] & vai_log[2], 1);
    chk("t1_en8",  en_log[8] & vai_log[8], 1);
    chk("t1_en14", en_log[14] & vai_log[14], 1);
    chk("t1_nstrobe", cnt_en(), 3);
    chk("t1_pronto20", pr_log[20], 1);
    chk("t1_npronto", cnt_pr(), 1);
    chk("t1_oc0", oc_log[0], 0);
    chk("t1_oc1", oc_log[1], 1);
    chk("t1_oc20", oc_log[20], 1);
    chk("t1_noc", cnt_oc(), 20);
    chk("t1_pos", pos, 13);

    // 2: 50 -> 48 downward
    start_move(50, 48, 18);
    chk("t2_dir2", {en_log[2], vai_log[2], vem_log[2]}, 3'b101);
    chk("t2_dir8", {en_log[8], vai_log[8], vem_log[8]}, 3'b101);
    chk("t2_nstrobe", cnt_en(), 2);
    chk("t2_pronto14", pr_log[14], 1);
    chk("t2_npronto", cnt_pr(), 1);
    chk("t2_pos", pos, 48);

    // 3: already at target
    start_move(0, 0, 6);
    chk("t3_nstrobe", cnt_en(), 0);
    chk("t3_pronto2", pr_log[2], 1);
    chk("t3_npronto", cnt_pr(), 1);

    // 4: out-of-range target rejected
    start_move(20, 100, 6);
    chk("t4_erro1", er_log[1], 1);
    chk("t4_nerro", cnt_er(), 1);
    chk("t4_noc", cnt_oc(), 0);
    chk("t4_nstrobe", cnt_en(), 0);

    // 5: 0 -> 99, second start ignored, cancel in third wait
    clear_logs();
    pos = '0; alvo = 7'd99;
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    while (c < 5) cyc();
    alvo = 7'd120; iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    while (c < 16) cyc();
    cancelar = 1'b1;
    cyc();
    cancelar = 1'b0;
    while (c <= 30) cyc();
    chk("t5_oc16", oc_log[16], 1);
    chk("t5_oc17", oc_log[17], 0);
    chk("t5_nstrobe", cnt_en(), 3);
    chk("t5_npronto", cnt_pr(), 0);
    chk("t5_nerro", cnt_er(), 0);
    chk("t5_pos", pos, 3);

    // 6: asynchronous reset in the middle of MOVE
    clear_logs();
    pos = '0; alvo = 7'd50;
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    cyc();
    #2;
    chk("t6_in_move", enable_mov, 1);
    zera_as_n = 1'b0;
    #1;
    chk("t6_async_outs", {enable_mov, vai, vem, ocupado, pronto, erro}, 0);
    @(posedge clock);
    #1;
    zera_as_n = 1'b1;
    #1;
    chk("t6_idle", ocupado, 0);
    chk("t6_pos_held", pos, 0);
    start_move(M - 1, M - 1, 6);
    chk("t6_pronto2", pr_log[2], 1);
    chk("t6_nstrobe", cnt_en(), 0);

    chk("never_both", both_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
